// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory (1-cycle read latency).
// Registered grants with round-robin on conflict and a bounded lock for bursts.
module mem_port_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          ReqA,
  input  logic          WeA,
  input  logic          LockA,
  input  logic [AW-1:0] AddrA,
  input  logic [DW-1:0] WDataA,
  output logic          GntA,
  output logic          RValidA,
  input  logic          ReqB,
  input  logic          WeB,
  input  logic          LockB,
  input  logic [AW-1:0] AddrB,
  input  logic [DW-1:0] WDataB,
  output logic          GntB,
  output logic          RValidB,
  output logic [DW-1:0] RData,
  output logic          MemEn,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  input  logic [DW-1:0] MemRData,
  output logic          Busy
);

  localparam int LCW = $clog2(LOCK_MAX + 1);
  localparam logic [LCW-1:0] LOCK_LIM = LCW'(LOCK_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2} state_t;

  state_t         state, state_nxt;
  logic [LCW-1:0] lock_cnt, lock_cnt_acc;
  logic           last_b;
  logic           acc_a, acc_b;
  logic           rvalid_a_p1, rvalid_b_p1;

  function automatic logic [LCW-1:0] sat_inc(input logic [LCW-1:0] v);
    return (v >= LOCK_LIM) ? LOCK_LIM : v + LCW'(1);
  endfunction

  assign acc_a = (state == OWN_A) & ReqA;
  assign acc_b = (state == OWN_B) & ReqB;

  // Lock count as it stands once this cycle's access is taken into account.
  always_comb begin
    lock_cnt_acc = lock_cnt;
    if (acc_a)      lock_cnt_acc = LockA ? sat_inc(lock_cnt) : '0;
    else if (acc_b) lock_cnt_acc = LockB ? sat_inc(lock_cnt) : '0;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ReqA && ReqB) state_nxt = last_b ? OWN_A : OWN_B;
        else if (ReqA)    state_nxt = OWN_A;
        else if (ReqB)    state_nxt = OWN_B;
        else              state_nxt = IDLE;
      end
      OWN_A: begin
        if (acc_a && LockA && ((lock_cnt_acc < LOCK_LIM) || !ReqB)) state_nxt = OWN_A;
        else if (ReqB) state_nxt = OWN_B;
        else if (ReqA) state_nxt = OWN_A;
        else           state_nxt = IDLE;
      end
      OWN_B: begin
        if (acc_b && LockB && ((lock_cnt_acc < LOCK_LIM) || !ReqA)) state_nxt = OWN_B;
        else if (ReqA) state_nxt = OWN_A;
        else if (ReqB) state_nxt = OWN_B;
        else           state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // p0 -> p1: read-return valid, lock count and round-robin pointer.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      rvalid_a_p1 <= 1'b0;
      rvalid_b_p1 <= 1'b0;
      lock_cnt    <= '0;
      last_b      <= 1'b1;
    end else begin
      rvalid_a_p1 <= acc_a & ~WeA;
      rvalid_b_p1 <= acc_b & ~WeB;
      lock_cnt    <= (state_nxt != state) ? '0 : lock_cnt_acc;
      if (acc_a)      last_b <= 1'b0;
      else if (acc_b) last_b <= 1'b1;
    end
  end

  always_comb begin
    GntA     = (state == OWN_A);
    GntB     = (state == OWN_B);
    Busy     = (state != IDLE);
    MemEn    = acc_a | acc_b;
    MemWe    = (acc_a & WeA) | (acc_b & WeB);
    MemAddr  = acc_b ? AddrB : AddrA;
    MemWData = acc_b ? WDataB : WDataA;
    RValidA  = rvalid_a_p1;
    RValidB  = rvalid_b_p1;
    RData    = MemRData;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a behavioural model of owner, lock count and memory.
module tb_mem_port_arbiter;

  localparam int LM = 4;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       ReqA, WeA, LockA, ReqB, WeB, LockB;
  logic [7:0] AddrA, WDataA, AddrB, WDataB;
  logic       GntA, GntB, RValidA, RValidB, MemEn, MemWe, Busy;
  logic [7:0] RData, MemAddr, MemWData;
  logic [7:0] MemRData = 8'h00;

  mem_port_arbiter #(.AW(8), .DW(8), .LOCK_MAX(LM)) dut (
    .Clock(Clock), .Reset(Reset),
    .ReqA(ReqA), .WeA(WeA), .LockA(LockA), .AddrA(AddrA), .WDataA(WDataA),
    .GntA(GntA), .RValidA(RValidA),
    .ReqB(ReqB), .WeB(WeB), .LockB(LockB), .AddrB(AddrB), .WDataB(WDataB),
    .GntB(GntB), .RValidB(RValidB),
    .RData(RData), .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemRData(MemRData), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  // Synchronous memory: 1-cycle read latency.
  logic [7:0] mem [256] = '{8'h10: 8'h5A, default: 8'h00};
  always @(posedge Clock) begin
    if (MemEn) begin
      if (MemWe) mem[MemAddr] <= MemWData;
      else       MemRData <= mem[MemAddr];
    end
  end

  // Reference model: owner 0=none 1=A 2=B.
  logic [7:0] mref [256] = '{8'h10: 8'h5A, default: 8'h00};
  int         m_own, m_cnt, m_last;
  bit         e_rva, e_rvb;
  logic [7:0] e_rdata;

  int n_vec = 0;
  int n_bad = 0;
  int hist[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic step(input bit rn, input bit ra, input bit wa, input bit la,
                      input logic [7:0] aa, input logic [7:0] da,
                      input bit rb, input bit wb, input bit lb,
                      input logic [7:0] ab, input logic [7:0] db);
    bit         req [1:2];
    bit         acc, we, lk;
    logic [7:0] ad, wd;
    int         oth, nxt, ncnt;
    Reset = rn; ReqA = ra; WeA = wa; LockA = la; AddrA = aa; WDataA = da;
    ReqB = rb; WeB = wb; LockB = lb; AddrB = ab; WDataB = db;
    #1;
    req[1] = ra; req[2] = rb;
    acc = (m_own != 0) && req[m_own];
    we  = (m_own == 2) ? wb : wa;
    lk  = (m_own == 2) ? lb : la;
    ad  = (acc && m_own == 2) ? ab : aa;
    wd  = (acc && m_own == 2) ? db : da;
    check("GntA", GntA, m_own == 1);
    check("GntB", GntB, m_own == 2);
    check("Busy", Busy, m_own != 0);
    check("MemEn", MemEn, acc);
    check("MemWe", MemWe, acc && we);
    check("MemAddr", MemAddr, ad);
    check("MemWData", MemWData, wd);
    check("RValidA", RValidA, e_rva);
    check("RValidB", RValidB, e_rvb);
    if (e_rva || e_rvb) check("RData", RData, e_rdata);
    hist.push_back(MemEn ? (GntA ? 1 : (GntB ? 2 : 3)) : 0);
    @(posedge Clock);
    // Model update for this edge.
    e_rva = acc && (m_own == 1) && !we;
    e_rvb = acc && (m_own == 2) && !we;
    if (acc && !we) e_rdata = mref[ad];
    if (acc && we)  mref[ad] = wd;
    if (!rn) begin
      m_own = 0; m_cnt = 0; m_last = 2; e_rva = 0; e_rvb = 0;
    end else begin
      if (m_own == 0) begin
        if (ra && rb)  nxt = (m_last == 1) ? 2 : 1;
        else if (ra)   nxt = 1;
        else if (rb)   nxt = 2;
        else           nxt = 0;
        ncnt = m_cnt;
      end else begin
        oth  = 3 - m_own;
        ncnt = m_cnt;
        if (acc) ncnt = lk ? ((m_cnt + 1 > LM) ? LM : m_cnt + 1) : 0;
        if (acc && lk && (ncnt < LM || !req[oth])) nxt = m_own;
        else if (req[oth])                         nxt = oth;
        else if (req[m_own])                       nxt = m_own;
        else                                       nxt = 0;
      end
      if (acc) m_last = m_own;
      m_cnt = (nxt != m_own) ? 0 : ncnt;
      m_own = nxt;
    end
    @(negedge Clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
  endtask

  int run_a, run_b, k;

  initial begin
    Reset = 0; ReqA = 0; WeA = 0; LockA = 0; AddrA = 0; WDataA = 0;
    ReqB = 0; WeB = 0; LockB = 0; AddrB = 0; WDataB = 0;
    m_own = 0; m_cnt = 0; m_last = 2; e_rva = 0; e_rvb = 0; e_rdata = 0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);

    // A reads 0x10, then drops ReqA while still granted.
    step(1, 1, 0, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    step(1, 1, 0, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    step(1, 0, 0, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    idle(2);

    // Simultaneous requests alternate.
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
    idle(2);

    // Locked burst by A with B waiting.
    hist.delete();
    step(1, 1, 0, 1, 8'h03, 8'h00, 0, 0, 0, 8'h04, 8'h00);
    for (int i = 0; i < 12; i++) step(1, 1, 0, 1, 8'h03, 8'h00, 1, 0, 0, 8'h04, 8'h00);
    k = 0;
    while (k < hist.size() && hist[k] != 1) k++;
    run_a = 0;
    while (k < hist.size() && hist[k] == 1) begin run_a++; k++; end
    run_b = 0;
    while (k < hist.size() && hist[k] == 2) begin run_b++; k++; end
    check("lock_burst_a", run_a, LM);
    check("lock_burst_b", run_b, 1);
    idle(2);

    // B writes 0x20, then A reads it back.
    step(1, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h20, 8'hC3);
    step(1, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h20, 8'hC3);
    step(1, 1, 0, 0, 8'h20, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    step(1, 1, 0, 0, 8'h20, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    step(1, 0, 0, 0, 8'h20, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    idle(2);

    // Reset asserted in the cycle A's read is granted, then B alone.
    step(1, 1, 0, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    step(0, 1, 0, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    step(1, 0, 0, 0, 8'h10, 8'h00, 1, 0, 0, 8'h10, 8'h00);
    step(1, 0, 0, 0, 8'h10, 8'h00, 1, 0, 0, 8'h10, 8'h00);
    idle(2);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) != 0),
           ($urandom_range(0, 3) != 0), $urandom_range(0, 1), ($urandom_range(0, 2) != 0),
           8'($urandom_range(0, 7) + 8'h30), 8'($urandom),
           ($urandom_range(0, 3) != 0), $urandom_range(0, 1), ($urandom_range(0, 2) != 0),
           8'($urandom_range(0, 7) + 8'h30), 8'($urandom));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
